// File: rtl/cis_line_capture.sv
// cis_line_capture
// Line capture sequencer between the CIS timing controller and the
// ping-pong line buffer RAM. Each SI start pulse waits PIX_OFFSET clocks,
// then streams PIXELS ADC samples into the current write bank and hands the
// finished line to the reader with a LINE_READY pulse.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   ENABLE              allows new line starts from idle
//   SI, SI_CNT          sensor start pulse and colour index (0=R,1=G,2=B)
//   ADC_DATA            pixel sample, valid every clock
//   RD_DONE             reader frees the oldest full bank
//   BUF_WE/ADDR/WDATA   buffer write port, address = {bank, pixel}
//   LINE_READY/BANK/COLOR  completed-line pulse with its bank and colour
//   FULL                per-bank full flags
//   BUSY                line in progress (offset wait or writes pending)
//   LINE_CNT, DROP_CNT  completed lines (wraps), dropped+aborted (saturates)
module cis_line_capture #(
   parameter int PIXELS     = 2592,
   parameter int PIX_OFFSET = 60,
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 12
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ENABLE,
   input  logic              SI,
   input  logic [1:0]        SI_CNT,
   input  logic [DATA_W-1:0] ADC_DATA,
   input  logic              RD_DONE,
   output logic              BUF_WE,
   output logic [ADDR_W:0]   BUF_ADDR,
   output logic [DATA_W-1:0] BUF_WDATA,
   output logic              LINE_READY,
   output logic              LINE_BANK,
   output logic [1:0]        LINE_COLOR,
   output logic [1:0]        FULL,
   output logic              BUSY,
   output logic [15:0]       LINE_CNT,
   output logic [7:0]        DROP_CNT
);

   localparam int OW = (PIX_OFFSET > 2) ? $clog2(PIX_OFFSET) : 1;
   // OFFSET lasts PIX_OFFSET-1 clocks: counter runs 0..PIX_OFFSET-2
   localparam logic [OW-1:0]     OFF_LAST = OW'(PIX_OFFSET - 2);
   localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(PIXELS - 1);

   typedef enum logic [1:0] {S_IDLE, S_OFFSET, S_CAPTURE, S_DONE} state_t;
   // With a one-clock offset there is nothing to wait for: go straight to capture
   localparam state_t S_FIRST = (PIX_OFFSET == 1) ? S_CAPTURE : S_OFFSET;

   state_t            state, state_nx;
   logic              si_d, si_rise;
   logic              rd_ok;
   logic [1:0]        full_eff;
   logic              start, abort, drop, wr, complete;
   logic [1:0]        color;
   logic [OW-1:0]     off_cnt;
   logic [ADDR_W-1:0] pix_cnt;
   logic              w_bank, r_bank;

   assign si_rise = SI & ~si_d;
   // RD_DONE only counts when the bank it points at is actually full
   assign rd_ok   = RD_DONE & FULL[r_bank];
   // Full flags as seen by a same-cycle start, with this cycle's free applied
   assign full_eff[0] = FULL[0] & ~(rd_ok & ~r_bank);
   assign full_eff[1] = FULL[1] & ~(rd_ok &  r_bank);

   // BUF_WE covers the DONE cycle, which carries the last write
   assign BUSY = (state == S_OFFSET) | (state == S_CAPTURE) | BUF_WE;

   always_ff @(posedge CLK) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      start    = 1'b0;
      abort    = 1'b0;
      drop     = 1'b0;
      wr       = 1'b0;
      complete = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (si_rise & ENABLE) begin
               if (full_eff[w_bank]) drop = 1'b1;
               else begin
                  start    = 1'b1;
                  state_nx = S_FIRST;
               end
            end
         end
         S_OFFSET: begin
            if (si_rise) begin
               abort    = 1'b1;
               state_nx = S_FIRST;
            end else if (off_cnt == OFF_LAST) state_nx = S_CAPTURE;
         end
         S_CAPTURE: begin
            if (si_rise) begin
               abort    = 1'b1;
               state_nx = S_FIRST;
            end else begin
               wr = 1'b1;
               if (pix_cnt == PIX_LAST) state_nx = S_DONE;
            end
         end
         S_DONE: begin
            complete = 1'b1;
            state_nx = S_IDLE;
            // A start here targets the bank after the one just completed
            if (si_rise & ENABLE) begin
               if (full_eff[~w_bank]) drop = 1'b1;
               else begin
                  start    = 1'b1;
                  state_nx = S_FIRST;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // w_bank only moves in DONE, so it doubles as the latched target bank of
   // the line in flight.
   always_ff @(posedge CLK) begin
      if (RST) begin
         si_d       <= 1'b0;
         color      <= 2'd0;
         off_cnt    <= '0;
         pix_cnt    <= '0;
         w_bank     <= 1'b0;
         r_bank     <= 1'b0;
         BUF_WE     <= 1'b0;
         BUF_ADDR   <= '0;
         BUF_WDATA  <= '0;
         LINE_READY <= 1'b0;
         LINE_BANK  <= 1'b0;
         LINE_COLOR <= 2'd0;
         FULL       <= 2'b00;
         LINE_CNT   <= 16'd0;
         DROP_CNT   <= 8'd0;
      end else begin
         si_d       <= SI;
         BUF_WE     <= wr;
         LINE_READY <= complete;
         if (start | abort) begin
            color   <= SI_CNT;
            off_cnt <= '0;
            pix_cnt <= '0;
         end else begin
            if (state == S_OFFSET) off_cnt <= off_cnt + 1'b1;
            if (wr)                pix_cnt <= pix_cnt + 1'b1;
         end
         if (wr) begin
            BUF_ADDR  <= {w_bank, pix_cnt};
            BUF_WDATA <= ADC_DATA;
         end
         if (complete) begin
            LINE_BANK  <= w_bank;
            LINE_COLOR <= color;
            LINE_CNT   <= LINE_CNT + 16'd1;
            w_bank     <= ~w_bank;
         end
         if (rd_ok) r_bank <= ~r_bank;
         FULL[0] <= full_eff[0] | (complete & ~w_bank);
         FULL[1] <= full_eff[1] | (complete &  w_bank);
         if ((drop | abort) && DROP_CNT != 8'hFF) DROP_CNT <= DROP_CNT + 8'd1;
      end
   end

endmodule

// File: tb/tb_cis_line_capture.sv
// tb_cis_line_capture
// Scoreboard bench: each accepted start pushes its expected writes
// ({addr,data,cycle}) and LINE_READY ({bank,colour,cycle}); negedge monitors
// pop and compare whenever the DUT strobes. ADC_DATA is the cycle counter so
// every write's data and timing are checkable.
module tb_cis_line_capture;

   localparam int PX = 2592;
   localparam int PO = 60;
   localparam int DW = 8;
   localparam int AW = 12;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          ENABLE = 1'b0;
   logic          SI = 1'b0;
   logic [1:0]    SI_CNT = 2'd0;
   logic [DW-1:0] ADC_DATA;
   logic          RD_DONE = 1'b0;
   logic          BUF_WE;
   logic [AW:0]   BUF_ADDR;
   logic [DW-1:0] BUF_WDATA;
   logic          LINE_READY;
   logic          LINE_BANK;
   logic [1:0]    LINE_COLOR;
   logic [1:0]    FULL;
   logic          BUSY;
   logic [15:0]   LINE_CNT;
   logic [7:0]    DROP_CNT;

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;
   logic [63:0] wq[$];
   logic [63:0] rq[$];
   logic [52:0] all_outs;

   cis_line_capture #(.PIXELS(PX), .PIX_OFFSET(PO), .DATA_W(DW), .ADDR_W(AW)) dut (
      .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .SI(SI), .SI_CNT(SI_CNT),
      .ADC_DATA(ADC_DATA), .RD_DONE(RD_DONE), .BUF_WE(BUF_WE),
      .BUF_ADDR(BUF_ADDR), .BUF_WDATA(BUF_WDATA), .LINE_READY(LINE_READY),
      .LINE_BANK(LINE_BANK), .LINE_COLOR(LINE_COLOR), .FULL(FULL),
      .BUSY(BUSY), .LINE_CNT(LINE_CNT), .DROP_CNT(DROP_CNT)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;
   assign ADC_DATA = cyc[7:0];
   assign all_outs = {BUF_WE, BUF_ADDR, BUF_WDATA, LINE_READY, LINE_BANK,
                      LINE_COLOR, FULL, BUSY, LINE_CNT, DROP_CNT};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge CLK) begin
      if (BUF_WE) begin
         if (wq.size() == 0) chk("wr_extra", {11'b0, BUF_ADDR, BUF_WDATA, cyc}, 64'd0);
         else                chk("wr", {11'b0, BUF_ADDR, BUF_WDATA, cyc}, wq.pop_front());
      end
      if (LINE_READY) begin
         if (rq.size() == 0) chk("rdy_extra", {29'b0, LINE_BANK, LINE_COLOR, cyc}, 64'd0);
         else                chk("rdy", {29'b0, LINE_BANK, LINE_COLOR, cyc}, rq.pop_front());
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Pixel n sampled at t0+PO+n, visible on the write port one cycle later
   task automatic push_line(input int t0, input logic bank, input logic [1:0] col,
                            input int nw, input bit rdy);
      for (int n = 0; n < nw; n++)
         wq.push_back({11'b0, bank, 12'(n), 8'(t0 + PO + n), 32'(t0 + PO + 1 + n)});
      if (rdy) rq.push_back({29'b0, bank, col, 32'(t0 + PO + PX + 1)});
   endtask

   // SI high for one sampling edge; t0 is the cycle that edge samples
   task automatic si_pulse(input logic [1:0] col, input logic rd, output int t0);
      tick();
      SI = 1'b1; SI_CNT = col; RD_DONE = rd;
      t0 = cyc;
      tick();
      SI = 1'b0; RD_DONE = 1'b0;
   endtask

   task automatic rd_pulse();
      tick();
      RD_DONE = 1'b1;
      tick();
      RD_DONE = 1'b0;
   endtask

   task automatic goto_cyc(input int c);
      while (cyc < c - 1) tick();
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((wq.size() != 0 || rq.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      chk("drain", 64'(wq.size() + rq.size()), 64'd0);
      repeat (3) tick();
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, dmy;
      repeat (3) tick();
      chk("reset_outs", 64'(all_outs), 64'd0);
      RST = 1'b0; ENABLE = 1'b1;
      tick();

      // single line: bank 0, colour 1
      si_pulse(2'd1, 1'b0, t0);
      push_line(t0, 1'b0, 2'd1, PX, 1'b1);
      chk("busy_start", 64'(BUSY), 64'd1);
      wait_drain(3000);
      chk("l1_full_cnt", {46'b0, FULL, LINE_CNT}, {46'b0, 2'b01, 16'd1});

      // ping-pong: second line to bank 1, third start dropped
      si_pulse(2'd2, 1'b0, t0);
      push_line(t0, 1'b1, 2'd2, PX, 1'b1);
      wait_drain(3000);
      chk("l2_full_cnt", {46'b0, FULL, LINE_CNT}, {46'b0, 2'b11, 16'd2});
      si_pulse(2'd0, 1'b0, dmy);
      repeat (80) tick();
      chk("drop1", {55'b0, BUSY, DROP_CNT}, {55'b0, 1'b0, 8'd1});
      rd_pulse();
      chk("rd_free0", 64'(FULL), 64'(2'b10));
      si_pulse(2'd0, 1'b0, t0);
      push_line(t0, 1'b0, 2'd0, PX, 1'b1);
      wait_drain(3000);
      chk("l3_full_cnt", {46'b0, FULL, LINE_CNT}, {46'b0, 2'b11, 16'd3});

      // RD_DONE with si_rise, both full: bank 1 freed and taken, no drop
      si_pulse(2'd1, 1'b1, t0);
      chk("simul", {53'b0, FULL, BUSY, DROP_CNT}, {53'b0, 2'b01, 1'b1, 8'd1});
      // abort 100 pixels into capture, restart on the same bank
      push_line(t0, 1'b1, 2'd1, 100, 1'b0);
      goto_cyc(t0 + PO + 100);
      si_pulse(2'd2, 1'b0, t1);
      chk("abort_t", 64'(t1 - t0), 64'(PO + 100));
      chk("abort_drop", 64'(DROP_CNT), 64'd2);
      push_line(t1, 1'b1, 2'd2, PX, 1'b1);
      wait_drain(3200);
      chk("l4_full_cnt", {46'b0, FULL, LINE_CNT}, {46'b0, 2'b11, 16'd4});

      // free both banks, then a stray RD_DONE is ignored
      rd_pulse();
      rd_pulse();
      chk("rd_both", 64'(FULL), 64'd0);
      rd_pulse();
      chk("rd_empty", {54'b0, FULL, DROP_CNT}, {54'b0, 2'b00, 8'd2});

      // ENABLE drops mid-line: line still completes, later starts ignored
      si_pulse(2'd1, 1'b0, t0);
      push_line(t0, 1'b0, 2'd1, PX, 1'b1);
      goto_cyc(t0 + 500);
      tick();
      ENABLE = 1'b0;
      wait_drain(3000);
      chk("l5_full_cnt", {46'b0, FULL, LINE_CNT}, {46'b0, 2'b01, 16'd5});
      si_pulse(2'd2, 1'b0, dmy);
      repeat (80) tick();
      chk("en_block", {55'b0, BUSY, DROP_CNT}, {55'b0, 1'b0, 8'd2});
      ENABLE = 1'b1;

      // reset at pixel 1000 of a bank-1 line
      si_pulse(2'd0, 1'b0, t0);
      push_line(t0, 1'b1, 2'd0, 1000, 1'b0);
      goto_cyc(t0 + PO + 1000);
      tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk("rst_mid_outs", 64'(all_outs), 64'd0);
      chk("rst_drain", 64'(wq.size()), 64'd0);
      si_pulse(2'd2, 1'b0, t0);
      push_line(t0, 1'b0, 2'd2, PX, 1'b1);
      wait_drain(3000);
      chk("post_rst", {46'b0, FULL, LINE_CNT}, {46'b0, 2'b01, 16'd1});

      // fill bank 1, then saturate DROP_CNT
      si_pulse(2'd1, 1'b0, t0);
      push_line(t0, 1'b1, 2'd1, PX, 1'b1);
      wait_drain(3000);
      chk("l7_full_cnt", {46'b0, FULL, LINE_CNT}, {46'b0, 2'b11, 16'd2});
      for (int i = 0; i < 254; i++) si_pulse(2'd0, 1'b0, dmy);
      chk("drop_254", 64'(DROP_CNT), 64'd254);
      si_pulse(2'd0, 1'b0, dmy);
      chk("drop_255", 64'(DROP_CNT), 64'd255);
      for (int i = 0; i < 45; i++) si_pulse(2'd0, 1'b0, dmy);
      repeat (5) tick();
      chk("drop_sat", {53'b0, FULL, BUSY, DROP_CNT}, {53'b0, 2'b11, 1'b0, 8'd255});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
